// File: rtl/fifo_drain_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_drain_ctrl_if
// Bundles the FIFO read-side signals and the downstream valid/ready handshake
// used by fifo_drain_ctrl.
//
// Signals
//   data_count  FIFO occupancy                     (fifo -> controller)
//   fifo_empty  FIFO empty flag                    (fifo -> controller)
//   buff_out    FIFO read data, 1 cycle after read (fifo -> controller)
//   read        FIFO pop strobe                    (controller -> fifo)
//   data_out    downstream data                    (controller -> consumer)
//   valid_out   data_out holds a valid word        (controller -> consumer)
//   ready_in    consumer accepts                   (consumer -> controller)
//
// Modports
//   master : the drain controller
//   slave  : the FIFO + consumer side (or a testbench standing in for them)
// ----------------------------------------------------------------------------
interface fifo_drain_ctrl_if #(
    parameter int MAIN_QUEUE_SIZE = 4,
    parameter int DATA_SIZE       = 4
);
    logic [MAIN_QUEUE_SIZE-1:0] data_count;
    logic                       fifo_empty;
    logic [DATA_SIZE-1:0]       buff_out;
    logic                       read;
    logic [DATA_SIZE-1:0]       data_out;
    logic                       valid_out;
    logic                       ready_in;

    modport master (
        input  data_count,
        input  fifo_empty,
        input  buff_out,
        input  ready_in,
        output read,
        output data_out,
        output valid_out
    );

    modport slave (
        output data_count,
        output fifo_empty,
        output buff_out,
        output ready_in,
        input  read,
        input  data_out,
        input  valid_out
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_drain_ctrl
// Read-side controller for the fifo block. Pops words from the FIFO and
// forwards them downstream over valid/ready. The FIFO's 1-cycle read latency
// is absorbed by a 2-entry skid buffer, so downstream stalls never lose or
// duplicate a word.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   enable       1 = drain the FIFO; 0 = stop issuing reads, flush the skid
//   bus          fifo_drain_ctrl_if.master (data_count, fifo_empty, buff_out,
//                read, data_out, valid_out, ready_in)
//   idle         1 in IDLE with the skid empty and no read in flight
//   error_drain  sticky error flag, present only when FIFO_DRAIN_ERR_EN is
//                defined
//
// Optional feature macro: FIFO_DRAIN_ERR_EN
//   Defined: error_drain is set the cycle after a read issued while the FIFO
//   reports empty, or after a capture into a full skid; cleared only by reset.
//   Undefined: no error_drain port and no checking logic.
// ----------------------------------------------------------------------------
module fifo_drain_ctrl #(
    parameter int MAIN_QUEUE_SIZE = 4,
    parameter int DATA_SIZE       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    fifo_drain_ctrl_if.master  bus,
    output logic               idle
`ifdef FIFO_DRAIN_ERR_EN
    ,
    output logic               error_drain
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_inflight;
    logic [1:0]           r_occ;
    logic [DATA_SIZE-1:0] r_skid0;      // head, drives data_out
    logic [DATA_SIZE-1:0] r_skid1;

    logic                 w_pop;
    logic                 w_cap;
    logic [2:0]           w_slots;
    logic                 w_count_ok;
    logic                 w_read;
    logic                 w_idle;

    assign w_pop = (r_occ != 2'd0) & bus.ready_in;
    assign w_cap = r_inflight;

    // Skid entries that will be committed once this cycle's pop is done:
    // words already held plus the word arriving from the in-flight read.
    // pop implies occ>=1, so this never underflows.
    assign w_slots = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    // data_count still counts the word being read last cycle, so with a read
    // in flight the FIFO must report at least 2 before another pop.
    assign w_count_ok = bus.data_count > MAIN_QUEUE_SIZE'(r_inflight);

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM: next-state logic ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!enable) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                // Re-enable resumes without waiting for the skid to empty.
                if (enable) begin
                    w_state_nxt = S_RUN;
                end else if ((r_occ == 2'd0) && !r_inflight) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        w_read = 1'b0;
        w_idle = 1'b0;
        case (r_state)
            S_RUN: begin
                // fifo_empty overrides a possibly stale data_count.
                w_read = enable & w_count_ok & (w_slots < 3'd2) & ~bus.fifo_empty;
            end
            S_IDLE: begin
                w_idle = (r_occ == 2'd0) & ~r_inflight;
            end
            default: begin
                w_read = 1'b0;
                w_idle = 1'b0;
            end
        endcase
    end

    // ---- Read pipeline: inflight marks buff_out valid this cycle ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_read;
        end
    end

    // ---- Skid buffer: capture at tail, pop at head, order preserved ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ   <= 2'd0;
            r_skid0 <= '0;
            r_skid1 <= '0;
        end else begin
            case ({w_cap, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_skid0 <= bus.buff_out;
                        r_occ   <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_skid1 <= bus.buff_out;
                        r_occ   <= 2'd2;
                    end
                    // occ==2 cannot be reached by the read rule; the word
                    // would be dropped and is flagged when checking is built.
                end
                2'b01: begin
                    r_skid0 <= r_skid1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous capture and pop: occupancy unchanged.
                    if (r_occ == 2'd1) begin
                        r_skid0 <= bus.buff_out;
                    end else begin
                        r_skid0 <= r_skid1;
                        r_skid1 <= bus.buff_out;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

`ifdef FIFO_DRAIN_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (w_read & bus.fifo_empty) | (w_cap & (r_occ == 2'd2));
        end
    end

    assign error_drain = r_err;
`endif

    assign bus.read      = w_read;
    assign bus.data_out  = r_skid0;
    assign bus.valid_out = (r_occ != 2'd0);
    assign idle          = w_idle;

endmodule
